// File: rtl/pulse_period_ctrl.sv
// ============================================================================
// Module   : pulse_period_ctrl
// Purpose  : Converts two raw active-low push-buttons into the period word
//            for the pulse generator. Each key is synchronised and debounced.
//            An up/down press steps the period with saturation, and pressing
//            both keys restores the default period.
// Options  : `define PULSE_PERIOD_AUTO_REPEAT_EN to auto-repeat steps while a
//            key is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_period_ctrl #(
    parameter int N            = 26,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int STEP         = 50000,
    parameter int PERIOD_MIN   = 100000,
    parameter int PERIOD_MAX   = 50000000,
    parameter int PERIOD_INIT  = 25000000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_up_n,
    input  logic         key_down_n,
    output logic [N-1:0] period_param,
    output logic         param_valid,
    output logic         at_min,
    output logic         at_max
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_db_w          = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYC - 1);

    // Wide (N+1 bit) copies let the saturation compares see carries.
    localparam logic [N:0]   c_step_w      = (N+1)'(STEP);
    localparam logic [N:0]   c_max_w       = (N+1)'(PERIOD_MAX);
    localparam logic [N:0]   c_min_step_w  = (N+1)'(PERIOD_MIN) + (N+1)'(STEP);
    localparam logic [N-1:0] c_step_n      = N'(STEP);
    localparam logic [N-1:0] c_min_n       = N'(PERIOD_MIN);
    localparam logic [N-1:0] c_max_n       = N'(PERIOD_MAX);
    localparam logic [N-1:0] c_init_n      = N'(PERIOD_INIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]   w_key_raw_n;   // [0] = up, [1] = down
    logic [1:0]   w_pressed;     // debounced, active-high
    logic         w_up;
    logic         w_dn;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_held_up;     // which key put us into HELD
    logic         w_held_up_nxt;

    logic [N-1:0] r_period;
    logic [N-1:0] w_period_nxt;
    logic         r_valid;
    logic         r_at_min;
    logic         r_at_max;

    logic [N:0]   w_cur;
    logic [N:0]   w_inc_raw;
    logic [N-1:0] w_inc_sat;
    logic [N-1:0] w_dec_sat;
    logic [N-1:0] w_step_held;
    logic         w_held_key;
    logic         w_other_key;

    assign w_key_raw_n = {key_down_n, key_up_n};

    // ------------------------------------------------------------------------
    // Per-key synchroniser and debouncer
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic              r_meta_n;
        logic              r_sync_n;
        logic              r_db_n;
        logic [c_db_w-1:0] r_cnt;

        // Two-flop synchroniser; idles at "released" so reset never looks like a press.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_meta_n <= 1'b1;
                r_sync_n <= 1'b1;
            end else begin
                r_meta_n <= w_key_raw_n[gi];
                r_sync_n <= r_meta_n;
            end
        end

        // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_db_n <= 1'b1;
                r_cnt  <= '0;
            end else if (r_sync_n == r_db_n) begin
                r_cnt  <= '0;
            end else if (r_cnt == c_db_last) begin
                r_db_n <= r_sync_n;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        assign w_pressed[gi] = ~r_db_n;
    end

    assign w_up = w_pressed[0];
    assign w_dn = w_pressed[1];

    // ------------------------------------------------------------------------
    // Saturating step arithmetic
    // ------------------------------------------------------------------------
    assign w_cur     = {1'b0, r_period};
    assign w_inc_raw = w_cur + c_step_w;
    assign w_inc_sat = (w_inc_raw > c_max_w) ? c_max_n : w_inc_raw[N-1:0];
    // Guard against going under PERIOD_MIN before subtracting, so the
    // subtraction itself can never wrap.
    assign w_dec_sat = (w_cur < c_min_step_w) ? c_min_n : (r_period - c_step_n);

    assign w_step_held = r_held_up ? w_inc_sat : w_dec_sat;
    assign w_held_key  = r_held_up ? w_up : w_dn;
    assign w_other_key = r_held_up ? w_dn : w_up;

    // ------------------------------------------------------------------------
    // Optional auto-repeat timer
    // ------------------------------------------------------------------------
`ifdef PULSE_PERIOD_AUTO_REPEAT_EN
    localparam int c_rep_max = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);
    localparam logic [c_rep_w-1:0] c_rep_dly_last  = c_rep_w'(REPEAT_DLY - 1);
    localparam logic [c_rep_w-1:0] c_rep_rate_last = c_rep_w'(REPEAT_RATE - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_first;   // still waiting for the initial hold delay
    logic               w_rep_fire;

    assign w_rep_fire = r_rep_first ? (r_rep_cnt == c_rep_dly_last)
                                    : (r_rep_cnt == c_rep_rate_last);

    // Hold timer: counts only while HELD persists, restarts after each repeat step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if ((r_state != S_HELD) || (w_state_nxt != S_HELD)) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------

    // State register and held-key memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_held_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_held_up <= w_held_up_nxt;
        end
    end

    // Next state and next period value.
    always_comb begin
        w_state_nxt   = r_state;
        w_held_up_nxt = r_held_up;
        w_period_nxt  = r_period;
        case (r_state)
            S_IDLE: begin
                if (w_up && w_dn) begin
                    w_period_nxt = c_init_n;
                    w_state_nxt  = S_LOCK;
                end else if (w_up) begin
                    w_period_nxt  = w_inc_sat;
                    w_held_up_nxt = 1'b1;
                    w_state_nxt   = S_HELD;
                end else if (w_dn) begin
                    w_period_nxt  = w_dec_sat;
                    w_held_up_nxt = 1'b0;
                    w_state_nxt   = S_HELD;
                end
            end
            S_HELD: begin
                if (w_other_key) begin
                    w_period_nxt = c_init_n;
                    w_state_nxt  = S_LOCK;
                end else if (!w_held_key) begin
                    w_state_nxt  = S_IDLE;
                end
`ifdef PULSE_PERIOD_AUTO_REPEAT_EN
                else if (w_rep_fire) begin
                    w_period_nxt = w_step_held;
                end
`endif
            end
            S_LOCK: begin
                // Wait for both keys to be let go before accepting new presses.
                if (!w_up && !w_dn) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifndef PULSE_PERIOD_AUTO_REPEAT_EN
    // Without auto-repeat the held step value has no consumer.
    logic w_unused_step;
    assign w_unused_step = ^w_step_held;
`endif

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------

    // Period, change strobe and bound flags all update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= c_init_n;
            r_valid  <= 1'b0;
            r_at_min <= (c_init_n == c_min_n);
            r_at_max <= (c_init_n == c_max_n);
        end else begin
            r_period <= w_period_nxt;
            r_valid  <= (w_period_nxt != r_period);
            r_at_min <= (w_period_nxt == c_min_n);
            r_at_max <= (w_period_nxt == c_max_n);
        end
    end

    assign period_param = r_period;
    assign param_valid  = r_valid;
    assign at_min       = r_at_min;
    assign at_max       = r_at_max;

endmodule

`default_nettype wire

// File: tb/tb_pulse_period_ctrl.sv
// ============================================================================
// Module   : tb_pulse_period_ctrl
// Purpose  : Directed self-checking bench for pulse_period_ctrl. A reference
//            model predicts each period change and queues it; a monitor pops
//            and compares on every param_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_period_ctrl;

    localparam int N     = 8;
    localparam int DEB   = 4;
    localparam int STEP  = 10;
    localparam int PMIN  = 20;
    localparam int PMAX  = 60;
    localparam int PINIT = 40;
    localparam int RDLY  = 8;
    localparam int RRATE = 4;
    localparam int HOLD  = 8;   // short enough that no auto-repeat can occur

    logic         clk = 1'b0;
    logic         reset_n;
    logic         key_up_n;
    logic         key_down_n;
    logic [N-1:0] period_param;
    logic         param_valid;
    logic         at_min;
    logic         at_max;

    pulse_period_ctrl #(
        .N            (N),
        .DEBOUNCE_CYC (DEB),
        .STEP         (STEP),
        .PERIOD_MIN   (PMIN),
        .PERIOD_MAX   (PMAX),
        .PERIOD_INIT  (PINIT),
        .REPEAT_DLY   (RDLY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_up_n     (key_up_n),
        .key_down_n   (key_down_n),
        .period_param (period_param),
        .param_valid  (param_valid),
        .at_min       (at_min),
        .at_max       (at_max)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [N-1:0] per;
        logic         amin;
        logic         amax;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model;

    // ------------------------------------------------------------------------
    // Scoreboard monitor: every pulse must match the oldest prediction
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && param_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_pulse observed period=%0d required no pulse", period_param);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                assert ({period_param, at_min, at_max} === {e.per, e.amin, e.amax}) else begin
                    n_err++;
                    $error("FAIL pulse_value observed per=%0d min=%0b max=%0b required per=%0d min=%0b max=%0b",
                           period_param, at_min, at_max, e.per, e.amin, e.amax);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        exp_t e;
        e.per  = N'(v);
        e.amin = (v == PMIN);
        e.amax = (v == PMAX);
        exp_q.push_back(e);
    endtask

    task automatic model_up();
        int nv;
        nv = (model + STEP > PMAX) ? PMAX : model + STEP;
        if (nv != model) push(nv);
        model = nv;
    endtask

    task automatic model_dn();
        int nv;
        nv = (model < PMIN + STEP) ? PMIN : model - STEP;
        if (nv != model) push(nv);
        model = nv;
    endtask

    task automatic model_restore();
        if (model != PINIT) push(PINIT);
        model = PINIT;
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        if (up) key_up_n = 1'b0;
        if (dn) key_down_n = 1'b0;
        tick(hold);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        tick(12);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_period"}, period_param, model);
        chk({tag, "_at_min"}, at_min, (model == PMIN));
        chk({tag, "_at_max"}, at_max, (model == PMAX));
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n0;
        int c0;

        reset_n    = 1'b0;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        model      = PINIT;
        tick(3);
        chk("rst_period", period_param, PINIT);
        chk("rst_valid",  param_valid, 0);
        chk("rst_at_min", at_min, 0);
        chk("rst_at_max", at_max, 0);
        reset_n = 1'b1;
        tick(3);

        // Single steps up to the upper bound, then one saturated press.
        model_up(); press(1'b1, 1'b0, HOLD); chk_state("up1");
        model_up(); press(1'b1, 1'b0, HOLD); chk_state("up2");
        model_up(); press(1'b1, 1'b0, HOLD); chk_state("up_sat");

        // Asynchronous reset while a key is held in HELD.
        model_dn();
        key_down_n = 1'b0;
        tick(8);
        chk("held_step", period_param, model);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_period", period_param, PINIT);
        chk("async_rst_valid",  param_valid, 0);
        chk("async_rst_at_max", at_max, 0);
        model = PINIT;
        tick(2);
        reset_n = 1'b1;
        // Key still held: it must debounce again and give exactly one step.
        model_dn();
        tick(8);
        key_down_n = 1'b1;
        tick(12);
        chk_state("post_rst_step");

        // Three-cycle glitch is shorter than the debounce window.
        key_down_n = 1'b0;
        tick(3);
        key_down_n = 1'b1;
        tick(12);
        chk_state("glitch");

        // Back to 40, then five down presses saturating at the lower bound.
        model_up(); press(1'b1, 1'b0, HOLD); chk_state("back_to_init");
        n0 = pulse_cyc.size();
        repeat (5) begin
            model_dn();
            press(1'b0, 1'b1, HOLD);
        end
        chk("dn_pulse_count", pulse_cyc.size() - n0, 2);
        chk_state("dn_sat");

        // Long hold on up from the lower bound.
        n0 = pulse_cyc.size();
`ifdef PULSE_PERIOD_AUTO_REPEAT_EN
        repeat (4) model_up();
`else
        model_up();
`endif
        key_up_n = 1'b0;
        tick(40);
        key_up_n = 1'b1;
        tick(12);
        chk_state("long_hold");
`ifdef PULSE_PERIOD_AUTO_REPEAT_EN
        chk("hold_pulse_count", pulse_cyc.size() - n0, 4);
        chk("rep_first_gap", pulse_cyc[n0+1] - pulse_cyc[n0], RDLY);
        chk("rep_gap_2",     pulse_cyc[n0+2] - pulse_cyc[n0+1], RRATE);
        chk("rep_gap_3",     pulse_cyc[n0+3] - pulse_cyc[n0+2], RRATE);
`else
        chk("hold_pulse_count", pulse_cyc.size() - n0, 1);
`endif

        // Both keys together restore the default; repeating it gives no pulse.
        model_restore(); press(1'b1, 1'b1, HOLD); chk_state("restore");
        n0 = pulse_cyc.size();
        model_restore(); press(1'b1, 1'b1, HOLD);
        chk("restore_again_pulses", pulse_cyc.size() - n0, 0);

        // Up held, then down joins: restore and lock out stepping.
        model_up();
        key_up_n = 1'b0;
        tick(7);
        chk("held_up_period", period_param, model);
        model_restore();
        key_down_n = 1'b0;
        tick(10);
        chk_state("other_key_restore");
        key_down_n = 1'b1;
        tick(12);
        chk_state("lock_up_still_held");
        key_up_n = 1'b1;
        tick(12);
        model_up(); press(1'b1, 1'b0, HOLD); chk_state("after_lock");

        // Bouncing down key: only the final stable low is accepted.
        n0 = pulse_cyc.size();
        key_down_n = 1'b0; tick(2);
        key_down_n = 1'b1; tick(2);
        key_down_n = 1'b0; tick(2);
        key_down_n = 1'b1; tick(2);
        key_down_n = 1'b0;
        c0 = cyc;
        model_dn();
        tick(HOLD);
        key_down_n = 1'b1;
        tick(12);
        chk("bounce_pulse_count", pulse_cyc.size() - n0, 1);
        chk("bounce_latency", (pulse_cyc.size() > n0) ? pulse_cyc[n0] - c0 : -1, 7);
        chk_state("bounce");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
